ext_irq_ctrl: RTL and testbench

- Machine-level external interrupt controller. Sits directly upstream of the core's CSR/trap unit.
- Collects NUM_SRC asynchronous peripheral interrupt lines and applies per-source edge/level gateways, enables and priorities.
- Drives a single meip line into the CSR unit. Consumes the CSR unit's irq_ack pulse as an automatic claim.
- Software configures it and claims/completes sources through a simple memory-mapped slave port.

---
 rtl/ext_irq_ctrl.sv | 139 +++++++++++++
 tb/tb_ext_irq_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_irq_ctrl.sv
// Machine-level external interrupt controller: synchronises peripheral lines, gates them into
// pending bits, arbitrates by priority and hands the winner to the CSR unit via meip/claim.
module ext_irq_ctrl #(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               bus_sel,
    input  logic               bus_we,
    input  logic [7:0]         bus_addr,
    input  logic [31:0]        bus_wdata,
    output logic [31:0]        bus_rdata,
    input  logic               irq_ack,
    output logic               meip,
    output logic [4:0]         claim_id
);

    localparam logic [5:0] A_PEND  = 6'h10;
    localparam logic [5:0] A_EN    = 6'h11;
    localparam logic [5:0] A_TRIG  = 6'h12;
    localparam logic [5:0] A_THR   = 6'h13;
    localparam logic [5:0] A_CLAIM = 6'h14;

    logic [NUM_SRC-1:0] s1_q, s2_q, s3_q;
    logic [NUM_SRC-1:0] pending_q, enable_q, trigger_q;
    logic [PRIO_W-1:0]  prio_q [NUM_SRC];
    logic [PRIO_W-1:0]  threshold_q;
    logic               claim_valid_q;
    logic [4:0]         claim_id_q;
    logic               meip_q;
    logic [31:0]        rdata_q;

    logic [NUM_SRC-1:0] pending_d, set_mask, clr_mask, claimed_mask;
    logic [PRIO_W-1:0]  best_prio;
    logic [4:0]         best_id;
    logic [5:0]         word;
    logic               rd_en, wr_en, claim_req, complete;
    logic [31:0]        rd_data;
    logic               unused_bits;

    assign word        = bus_addr[7:2];
    assign rd_en       = bus_sel & ~bus_we;
    assign wr_en       = bus_sel & bus_we;
    assign unused_bits = ^{bus_addr[1:0], bus_wdata};

    // Strict '>' while scanning upward in ID keeps the lowest ID on priority ties.
    always_comb begin
        best_prio    = '0;
        best_id      = '0;
        claimed_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claimed_mask[i] = claim_valid_q && (claim_id_q == 5'(i + 1));
            if (pending_q[i] && enable_q[i] && !claimed_mask[i] && (prio_q[i] > best_prio)) begin
                best_prio = prio_q[i];
                best_id   = 5'(i + 1);
            end
        end
    end

    assign claim_req = (irq_ack || (rd_en && word == A_CLAIM)) && !claim_valid_q && (best_id != 5'd0);
    assign complete  = wr_en && (word == A_CLAIM) && claim_valid_q && (bus_wdata[4:0] == claim_id_q);

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            set_mask[i] = trigger_q[i] ? (s2_q[i] & ~s3_q[i])
                                       : (s2_q[i] & ~pending_q[i] & ~claimed_mask[i]);
            clr_mask[i] = claim_req && (best_id == 5'(i + 1));
        end
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    always_comb begin
        rd_data = '0;
        case (word)
            A_PEND:  rd_data = 32'(pending_q);
            A_EN:    rd_data = 32'(enable_q);
            A_TRIG:  rd_data = 32'(trigger_q);
            A_THR:   rd_data = 32'(threshold_q);
            A_CLAIM: rd_data = claim_req ? 32'(best_id) : 32'(claim_id_q);
            default: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (word == 6'(i)) rd_data = 32'(prio_q[i]);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q          <= '0;
            s2_q          <= '0;
            s3_q          <= '0;
            pending_q     <= '0;
            enable_q      <= '0;
            trigger_q     <= '0;
            threshold_q   <= '0;
            claim_valid_q <= 1'b0;
            claim_id_q    <= '0;
            meip_q        <= 1'b0;
            rdata_q       <= '0;
            for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
        end else begin
            s1_q      <= src_irq;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            pending_q <= pending_d;
            if (wr_en) begin
                case (word)
                    A_EN:   enable_q    <= bus_wdata[NUM_SRC-1:0];
                    A_TRIG: trigger_q   <= bus_wdata[NUM_SRC-1:0];
                    A_THR:  threshold_q <= bus_wdata[PRIO_W-1:0];
                    default: begin
                        for (int i = 0; i < NUM_SRC; i++) begin
                            if (word == 6'(i)) prio_q[i] <= bus_wdata[PRIO_W-1:0];
                        end
                    end
                endcase
            end
            if (claim_req) begin
                claim_valid_q <= 1'b1;
                claim_id_q    <= best_id;
            end else if (complete) begin
                claim_valid_q <= 1'b0;
                claim_id_q    <= '0;
            end
            meip_q <= (best_prio > threshold_q) && !claim_valid_q;
            if (rd_en) rdata_q <= rd_data;
        end
    end

    assign bus_rdata = rdata_q;
    assign meip      = meip_q;
    assign claim_id  = claim_id_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Scenario bench for ext_irq_ctrl: directed feature tests plus randomized level-source
// configurations checked against a priority-scan reference model.
module tb_ext_irq_ctrl;

    localparam int NS = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [NS-1:0] src_irq = '0;
    logic        bus_sel = 1'b0;
    logic        bus_we = 1'b0;
    logic [7:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        irq_ack = 1'b0;
    logic        meip;
    logic [4:0]  claim_id;

    int n_vec = 0;
    int n_err = 0;
    int m_prio [NS];

    ext_irq_ctrl #(.NUM_SRC(NS), .PRIO_W(3)) dut (
        .clk(clk), .reset(reset), .src_irq(src_irq),
        .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .irq_ack(irq_ack), .meip(meip), .claim_id(claim_id)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Highest priority first, lowest ID within a priority; 0 when nothing qualifies.
    function automatic logic [4:0] model_winner(input logic [NS-1:0] pend, input logic [NS-1:0] en,
                                                output int bp);
        bp = 0;
        for (int p = 7; p >= 1; p--) begin
            for (int i = 0; i < NS; i++) begin
                if (pend[i] && en[i] && m_prio[i] == p) begin
                    bp = p;
                    return 5'(i + 1);
                end
            end
        end
        return 5'd0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; src_irq = '0; bus_sel = 0; bus_we = 0; irq_ack = 0;
        bus_addr = '0; bus_wdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_sel = 1; bus_we = 1; bus_addr = a; bus_wdata = d;
        @(negedge clk);
        bus_sel = 0; bus_we = 0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_sel = 1; bus_we = 0; bus_addr = a;
        @(negedge clk);
        bus_sel = 0;
        d = bus_rdata;
    endtask

    task automatic pulse(input logic [NS-1:0] m);
        @(negedge clk);
        src_irq = src_irq | m;
        @(negedge clk);
        src_irq = src_irq & ~m;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        #1;
        n_vec++; if (meip !== 1'b0) begin n_err++; $display("FAIL reset_meip: got %b want 0", meip); end
        n_vec++; if (claim_id !== 5'd0) begin n_err++; $display("FAIL reset_claim_id: got %0d want 0", claim_id); end
        n_vec++; if (bus_rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %0h want 0", bus_rdata); end
        do_reset();
        rd(8'h44, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_enable: got %0h want 0", d); end
        rd(8'h0C, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_prio3: got %0h want 0", d); end
    endtask

    task automatic test_regmap();
        logic [31:0] d;
        do_reset();
        wr(8'h44, 32'hFFFF_FFFF);
        rd(8'h47, d);
        n_vec++; if (d !== 32'h0000_00FF) begin n_err++; $display("FAIL regmap_enable: got %0h want ff", d); end
        wr(8'h04, 32'h0000_00FF);
        rd(8'h04, d);
        n_vec++; if (d !== 32'h7) begin n_err++; $display("FAIL regmap_prio1: got %0h want 7", d); end
        wr(8'h60, 32'h1234_5678);
        rd(8'h60, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL regmap_unmapped: got %0h want 0", d); end
        wr(8'h40, 32'hFF);
        rd(8'h40, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL regmap_pend_ro: got %0h want 0", d); end
        wr(8'h4C, 32'hFFFF_FFFA);
        rd(8'h4C, d);
        n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL regmap_thresh: got %0h want 2", d); end
        repeat (3) @(negedge clk);
        n_vec++; if (bus_rdata !== 32'h2) begin n_err++; $display("FAIL regmap_rdata_hold: got %0h want 2", bus_rdata); end
    endtask

    task automatic test_edge_basic();
        logic [31:0] d;
        do_reset();
        wr(8'h08, 5); wr(8'h44, 32'h04); wr(8'h48, 32'h04); wr(8'h4C, 0);
        @(negedge clk);
        src_irq[2] = 1'b1;
        @(negedge clk);
        src_irq[2] = 1'b0;
        n_vec++; if (meip !== 1'b0) begin n_err++; $display("FAIL edge_latency_E0: got %b want 0", meip); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_vec++;
            if (meip !== (k == 3)) begin n_err++; $display("FAIL edge_latency_E%0d: got %b want %b", k, meip, k == 3); end
        end
        rd(8'h40, d);
        n_vec++; if (d !== 32'h04) begin n_err++; $display("FAIL edge_pending: got %0h want 4", d); end
        rd(8'h50, d);
        n_vec++; if (d !== 32'd3) begin n_err++; $display("FAIL edge_claim: got %0d want 3", d); end
        n_vec++; if (meip !== 1'b1) begin n_err++; $display("FAIL edge_meip_hold: got %b want 1", meip); end
        rd(8'h40, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL edge_pending_clr: got %0h want 0", d); end
        n_vec++; if (meip !== 1'b0) begin n_err++; $display("FAIL edge_meip_drop: got %b want 0", meip); end
        n_vec++; if (claim_id !== 5'd3) begin n_err++; $display("FAIL edge_claim_id: got %0d want 3", claim_id); end
        wr(8'h50, 3);
        n_vec++; if (claim_id !== 5'd0) begin n_err++; $display("FAIL edge_complete: got %0d want 0", claim_id); end
    endtask

    task automatic test_level_prio();
        logic [31:0] d;
        do_reset();
        wr(8'h04, 2); wr(8'h10, 6); wr(8'h44, 32'h12);
        @(negedge clk);
        src_irq[1] = 1'b1; src_irq[4] = 1'b1;
        repeat (5) @(negedge clk);
        n_vec++; if (meip !== 1'b1) begin n_err++; $display("FAIL level_meip: got %b want 1", meip); end
        rd(8'h50, d);
        n_vec++; if (d !== 32'd5) begin n_err++; $display("FAIL level_claim1: got %0d want 5", d); end
        repeat (4) @(negedge clk);
        rd(8'h40, d);
        n_vec++; if (d !== 32'h02) begin n_err++; $display("FAIL level_no_repend: got %0h want 2", d); end
        src_irq[4] = 1'b0;
        repeat (4) @(negedge clk);
        wr(8'h50, 5);
        n_vec++; if (claim_id !== 5'd0) begin n_err++; $display("FAIL level_complete: got %0d want 0", claim_id); end
        rd(8'h50, d);
        n_vec++; if (d !== 32'd2) begin n_err++; $display("FAIL level_claim2: got %0d want 2", d); end
        rd(8'h40, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL level_pending2: got %0h want 0", d); end
        src_irq[1] = 1'b0;
        repeat (4) @(negedge clk);
        wr(8'h50, 2);
    endtask

    task automatic test_tie();
        logic [31:0] d;
        do_reset();
        wr(8'h00, 4); wr(8'h0C, 4); wr(8'h44, 32'h09); wr(8'h48, 32'h09);
        pulse(8'h09);
        repeat (4) @(negedge clk);
        rd(8'h40, d);
        n_vec++; if (d !== 32'h09) begin n_err++; $display("FAIL tie_pending: got %0h want 9", d); end
        rd(8'h50, d);
        n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL tie_claim1: got %0d want 1", d); end
        wr(8'h50, 1);
        rd(8'h50, d);
        n_vec++; if (d !== 32'd4) begin n_err++; $display("FAIL tie_claim2: got %0d want 4", d); end
        pulse(8'h08);
        repeat (4) @(negedge clk);
        rd(8'h40, d);
        n_vec++; if (d !== 32'h08) begin n_err++; $display("FAIL tie_repend_claimed: got %0h want 8", d); end
        n_vec++; if (meip !== 1'b0) begin n_err++; $display("FAIL tie_meip_claimed: got %b want 0", meip); end
        wr(8'h50, 4);
        repeat (3) @(negedge clk);
        n_vec++; if (meip !== 1'b1) begin n_err++; $display("FAIL tie_meip_rearb: got %b want 1", meip); end
        rd(8'h50, d);
        n_vec++; if (d !== 32'd4) begin n_err++; $display("FAIL tie_claim3: got %0d want 4", d); end
        wr(8'h50, 4);
    endtask

    task automatic test_threshold();
        logic [31:0] d;
        do_reset();
        wr(8'h14, 4); wr(8'h44, 32'h20); wr(8'h48, 32'h20); wr(8'h4C, 4);
        pulse(8'h20);
        repeat (5) @(negedge clk);
        n_vec++; if (meip !== 1'b0) begin n_err++; $display("FAIL thr_equal_blocks: got %b want 0", meip); end
        rd(8'h40, d);
        n_vec++; if (d !== 32'h20) begin n_err++; $display("FAIL thr_pending: got %0h want 20", d); end
        wr(8'h4C, 3);
        n_vec++; if (meip !== 1'b0) begin n_err++; $display("FAIL thr_meip_edge1: got %b want 0", meip); end
        @(negedge clk);
        n_vec++; if (meip !== 1'b1) begin n_err++; $display("FAIL thr_meip_edge2: got %b want 1", meip); end
        rd(8'h50, d);
        n_vec++; if (d !== 32'd6) begin n_err++; $display("FAIL thr_claim: got %0d want 6", d); end
    endtask

    task automatic test_ack();
        logic [31:0] d;
        do_reset();
        wr(8'h18, 7); wr(8'h04, 3); wr(8'h44, 32'h42); wr(8'h48, 32'h42);
        pulse(8'h42);
        repeat (4) @(negedge clk);
        n_vec++; if (meip !== 1'b1) begin n_err++; $display("FAIL ack_meip: got %b want 1", meip); end
        @(negedge clk);
        irq_ack = 1; bus_sel = 1; bus_we = 0; bus_addr = 8'h50;
        @(negedge clk);
        irq_ack = 0; bus_sel = 0;
        n_vec++; if (bus_rdata !== 32'd7) begin n_err++; $display("FAIL ack_read_same: got %0d want 7", bus_rdata); end
        n_vec++; if (claim_id !== 5'd7) begin n_err++; $display("FAIL ack_claim_id: got %0d want 7", claim_id); end
        rd(8'h40, d);
        n_vec++; if (d !== 32'h02) begin n_err++; $display("FAIL ack_one_claim: got %0h want 2", d); end
        @(negedge clk); irq_ack = 1;
        @(negedge clk); irq_ack = 0;
        n_vec++; if (claim_id !== 5'd7) begin n_err++; $display("FAIL ack_second: got %0d want 7", claim_id); end
        rd(8'h40, d);
        n_vec++; if (d !== 32'h02) begin n_err++; $display("FAIL ack_second_pend: got %0h want 2", d); end
        wr(8'h50, 2);
        n_vec++; if (claim_id !== 5'd7) begin n_err++; $display("FAIL ack_bad_complete: got %0d want 7", claim_id); end
        wr(8'h50, 7);
        n_vec++; if (claim_id !== 5'd0) begin n_err++; $display("FAIL ack_complete: got %0d want 0", claim_id); end
        rd(8'h50, d);
        n_vec++; if (d !== 32'd2) begin n_err++; $display("FAIL ack_next: got %0d want 2", d); end
        wr(8'h50, 2);
    endtask

    task automatic test_enable_reset();
        logic [31:0] d;
        do_reset();
        wr(8'h00, 3); wr(8'h08, 5);
        @(negedge clk);
        src_irq[0] = 1'b1; src_irq[2] = 1'b1;
        repeat (5) @(negedge clk);
        n_vec++; if (meip !== 1'b0) begin n_err++; $display("FAIL en_meip_off: got %b want 0", meip); end
        rd(8'h50, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL en_claim_none: got %0d want 0", d); end
        rd(8'h40, d);
        n_vec++; if (d !== 32'h05) begin n_err++; $display("FAIL en_pending: got %0h want 5", d); end
        wr(8'h44, 32'h01);
        @(negedge clk);
        n_vec++; if (meip !== 1'b1) begin n_err++; $display("FAIL en_meip_on: got %b want 1", meip); end
        @(negedge clk); irq_ack = 1;
        @(negedge clk); irq_ack = 0;
        n_vec++; if (claim_id !== 5'd1) begin n_err++; $display("FAIL en_ack_claim: got %0d want 1", claim_id); end
        rd(8'h50, d);
        n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL en_read_claimed: got %0d want 1", d); end
        src_irq = '0;
        #2 reset = 1'b1;
        #1;
        n_vec++; if (meip !== 1'b0) begin n_err++; $display("FAIL rst_mid_meip: got %b want 0", meip); end
        n_vec++; if (claim_id !== 5'd0) begin n_err++; $display("FAIL rst_mid_claim: got %0d want 0", claim_id); end
        n_vec++; if (bus_rdata !== 32'd0) begin n_err++; $display("FAIL rst_mid_rdata: got %0h want 0", bus_rdata); end
        @(negedge clk);
        reset = 1'b0;
        rd(8'h40, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_mid_pending: got %0h want 0", d); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [NS-1:0] en, pend;
        logic [4:0] w;
        int thr, bp;
        for (int it = 0; it < 12; it++) begin
            do_reset();
            for (int i = 0; i < NS; i++) begin
                m_prio[i] = $urandom_range(0, 7);
                wr(8'(4 * i), 32'(m_prio[i]));
            end
            en   = NS'($urandom);
            pend = NS'($urandom);
            thr  = $urandom_range(0, 6);
            wr(8'h44, 32'(en));
            wr(8'h4C, 32'(thr));
            @(negedge clk);
            src_irq = pend;
            repeat (5) @(negedge clk);
            src_irq = '0;
            repeat (4) @(negedge clk);
            for (int r = 0; r <= NS; r++) begin
                w = model_winner(pend, en, bp);
                repeat (2) @(negedge clk);
                n_vec++;
                if (meip !== (bp > thr)) begin n_err++; $display("FAIL rand_meip it%0d r%0d: got %b want %b", it, r, meip, bp > thr); end
                rd(8'h50, d);
                n_vec++;
                if (d !== 32'(w)) begin n_err++; $display("FAIL rand_claim it%0d r%0d: got %0d want %0d", it, r, d, w); end
                if (w == 5'd0) break;
                pend[w - 1] = 1'b0;
                wr(8'h50, 32'(w));
            end
            rd(8'h40, d);
            n_vec++;
            if (d !== 32'(pend)) begin n_err++; $display("FAIL rand_pending it%0d: got %0h want %0h", it, d, pend); end
        end
    endtask

    initial begin
        test_reset();
        test_regmap();
        test_edge_basic();
        test_level_prio();
        test_tie();
        test_threshold();
        test_ack();
        test_enable_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
